// File: rtl/bin_to_bcd_if.sv
// Request/result bundle of the serial binary-to-BCD converter.
// The master issues start/bin_in; the slave returns busy/done/bcd_out/overflow.
interface bin_to_bcd_if #(
  parameter int BIN_WIDTH = 8,
  parameter int DIGITS    = 3
);
  logic                  start;
  logic [BIN_WIDTH-1:0]  bin_in;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd_out;
  logic                  overflow;

  modport master (
    output start, bin_in,
    input  busy, done, bcd_out, overflow
  );

  modport slave (
    input  start, bin_in,
    output busy, done, bcd_out, overflow
  );
endinterface

// File: rtl/bin_to_bcd_serial.sv
// Serial double-dabble converter: one binary bit per clock into DIGITS packed BCD digits.
// Carries out of the top digit are collected into a sticky overflow flag.
module bin_to_bcd_serial #(
  parameter int BIN_WIDTH = 8,
  parameter int DIGITS    = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  bin_to_bcd_if.slave  bus
);

  localparam int CNT_W = $clog2(BIN_WIDTH + 1);
  localparam int BCD_W = 4 * DIGITS;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t               state_r;
  logic [BIN_WIDTH-1:0] shreg_r;
  logic [BCD_W-1:0]     digits_r;
  logic [CNT_W-1:0]     cnt_r;
  logic                 ovf_acc_r;
  logic                 busy_r;
  logic                 done_r;
  logic [BCD_W-1:0]     bcd_r;
  logic                 overflow_r;

  logic [BCD_W-1:0]     adj_s;
  logic [BCD_W-1:0]     next_digits_s;
  logic [BIN_WIDTH-1:0] next_shreg_s;
  logic                 carry_s;

  function automatic logic [3:0] add3(input logic [3:0] d);
    logic [3:0] r;
    if (d >= 4'd5) begin
      r = d + 4'd3;
    end else begin
      r = d;
    end
    return r;
  endfunction

  // Per-digit +3 correction ahead of the doubling shift
  always_comb begin
    adj_s = '0;
    for (int i = 0; i < DIGITS; i++) begin
      adj_s[4*i +: 4] = add3(digits_r[4*i +: 4]);
    end
  end

  // The top digit's MSB falls off the chain; any 1 there means the value needs another digit
  always_comb begin
    carry_s       = adj_s[BCD_W-1];
    next_digits_s = {adj_s[BCD_W-2:0], shreg_r[BIN_WIDTH-1]};
    next_shreg_s  = {shreg_r[BIN_WIDTH-2:0], 1'b0};
  end

  // Control FSM with registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      shreg_r    <= '0;
      digits_r   <= '0;
      cnt_r      <= '0;
      ovf_acc_r  <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      bcd_r      <= '0;
      overflow_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          if (bus.start) begin
            shreg_r   <= bus.bin_in;
            digits_r  <= '0;
            cnt_r     <= CNT_W'(BIN_WIDTH);
            ovf_acc_r <= 1'b0;
            busy_r    <= 1'b1;
            state_r   <= SHIFT;
          end else begin
            state_r   <= IDLE;
          end
        end
        SHIFT: begin
          digits_r  <= next_digits_s;
          shreg_r   <= next_shreg_s;
          ovf_acc_r <= ovf_acc_r | carry_s;
          cnt_r     <= cnt_r - CNT_W'(1);
          if (cnt_r == CNT_W'(1)) begin
            bcd_r      <= next_digits_s;
            overflow_r <= ovf_acc_r | carry_s;
            done_r     <= 1'b1;
            busy_r     <= 1'b0;
            state_r    <= IDLE;
          end else begin
            done_r     <= 1'b0;
            state_r    <= SHIFT;
          end
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
  assign bus.bcd_out  = bcd_r;
  assign bus.overflow = overflow_r;

endmodule

// File: doc/bin_to_bcd_serial.md
Name: bin_to_bcd_serial

Overview:
- Sequential binary-to-BCD converter using the shift-and-add-3 (double-dabble) method.
- Sits directly upstream of the single-digit BCD adder stage and supplies its packed-BCD operands, one 4-bit digit per adder instance.
- Converts one unsigned binary word per request, processing one bit per clock.
- Reports done, busy and an overflow flag for values too large for the configured digit count.

Parameters:
- BIN_WIDTH, 8, width of the unsigned binary input (2..16).
- DIGITS, 3, number of BCD output digits (1..5).

Ports:
- clk  input  1  single system clock; all state updates on the rising edge.
- rst_n  input  1  reset; asynchronous and active-low.
- start  input  1  conversion request; sampled only in IDLE.
- bin_in  input  BIN_WIDTH  unsigned binary value; sampled only on the accepting edge.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse; bcd_out and overflow are valid with it.
- bcd_out  output  4*DIGITS  packed BCD result; [3:0] is units, [7:4] is tens, and so on. Held until the next completion.
- overflow  output  1  result exceeded DIGITS decimal digits; held with bcd_out.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state goes to IDLE.
  - busy=0, done=0, bcd_out=0, overflow=0.
  - Internal shift register, scratch digits and bit counter are all cleared.
- States: IDLE and SHIFT.
- IDLE, start=1 at edge k (accept):
  - shift register <= bin_in; scratch digits <= 0; counter <= BIN_WIDTH; overflow accumulator <= 0.
  - busy <= 1; state -> SHIFT.
- IDLE, start=0: hold; done <= 0.
- SHIFT, every edge:
  - Each scratch digit >= 5 gets +3 (4-bit, no carry out).
  - Then shift {digits, shift register} left by one; the shift register MSB enters units bit 0.
  - The bit leaving the top digit's MSB is ORed into the overflow accumulator.
  - counter decrements.
- Final SHIFT edge (counter == 1 before the edge, i.e. edge k+BIN_WIDTH):
  - bcd_out <= shifted digits; overflow <= accumulator including this shift's carry.
  - done <= 1; busy <= 0; state -> IDLE.
- Latency: bin_in sampled at edge k; done high during the cycle after edge k+BIN_WIDTH; busy high for exactly BIN_WIDTH cycles.
- done is a single-cycle pulse; it deasserts on the next edge regardless of start.
- start while busy=1 is ignored; bin_in changes while busy have no effect.
- Back-to-back: start=1 in the cycle done=1 is accepted, because state is already IDLE.
  - done clears at that edge; busy rises at that edge; throughput is one conversion per BIN_WIDTH+1 cycles.
- Overflow case: bcd_out holds the value modulo 10^DIGITS, with each digit a valid BCD value 0..9.
- Every digit in bcd_out is always 0..9 when done=1.
- Reset mid-conversion: conversion is abandoned, done is never asserted for it, and outputs return to reset values.

Test Plan:
- Default parameters, reset, start with bin_in=8'd0 -> done after 8 cycles; bcd_out=12'h000, overflow=0, busy high exactly 8 cycles.
- bin_in=8'd255 -> bcd_out=12'h255, overflow=0; bin_in=8'd99 -> bcd_out=12'h099; bin_in=8'd100 -> bcd_out=12'h100.
- Start with bin_in=8'd37, then assert start with bin_in=8'd200 on cycles 2..5 while busy -> single done; bcd_out=12'h037.
- Start with 8'd128, then start with 8'd64 in the done cycle -> first done shows 12'h128; second done exactly 9 cycles later shows 12'h064.
- Pull rst_n low at cycle 4 of a conversion of 8'd150 -> outputs go to 0 immediately (asynchronous), no done pulse; a new start of 8'd150 afterwards gives 12'h150.
- BIN_WIDTH=10, DIGITS=3: bin_in=10'd1023 -> bcd_out=12'h023, overflow=1; bin_in=10'd999 -> bcd_out=12'h999, overflow=0.
